// File: rtl/cv32e40p_obi_mem_arbiter_if.sv
// OBI request/response bundle for one master<->slave link.
//   req/addr/we/be/wdata : request fields, driven by the master side
//   gnt                  : request accepted this cycle, driven by the slave side
//   rvalid/rdata         : response, driven by the slave side
// The master modport is the view of whoever issues requests; the slave modport
// is the view of whoever accepts them.
interface cv32e40p_obi_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cv32e40p_obi_mem_arbiter.sv
// Two-master OBI arbiter in front of a single memory slave port.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   m0             : instruction master (read-only; its we/be/wdata are ignored,
//                    the slave sees we=0, be=4'hF, wdata=0)
//   m1             : data master
//   s              : shared memory slave port
//   outstanding_o  : accepted transactions still awaiting a response
//   err_o          : sticky, set when the slave responds with nothing outstanding
// Requests are arbitrated round-robin, a request that is presented but not yet
// granted keeps its master selected until granted (OBI request stability), and
// responses are routed back in acceptance order using a small FIFO of master IDs.
module cv32e40p_obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  cv32e40p_obi_mem_arbiter_if.slave            m0,
  cv32e40p_obi_mem_arbiter_if.slave            m1,
  cv32e40p_obi_mem_arbiter_if.master           s,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Pointer advance that also covers a single-entry FIFO.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    else                                  return p + 1'b1;
  endfunction

  // Control state
  logic             lock_q;
  logic             lock_id_q;
  logic             rr_q;        // master favoured on a tie (0 -> m0)
  logic             err_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  // Outstanding master IDs; contents are only meaningful below count_q.
  logic             fifo_q [MAX_OUTSTANDING];

  logic full;
  logic sel;
  logic sel_req;
  logic s_req;
  logic grant;
  logic pop;
  logic head;

  // Selection, slave request and response routing
  always_comb begin
    full = (count_q == CNT_W'(MAX_OUTSTANDING));

    if (lock_q)                 sel = lock_id_q;
    else if (m0.req && m1.req)  sel = rr_q;
    else if (m1.req)            sel = 1'b1;
    else                        sel = 1'b0;

    sel_req = sel ? m1.req : m0.req;
    // A full FIFO blocks new requests even if a response frees a slot this
    // cycle; the freed slot becomes usable next cycle.
    s_req   = sel_req && !full;
    grant   = s_req && s.gnt;

    pop  = s.rvalid && (count_q != '0);
    head = fifo_q[rd_ptr_q];
  end

  assign s.req   = s_req;
  assign s.addr  = sel ? m1.addr  : m0.addr;
  assign s.we    = sel && m1.we;
  assign s.be    = sel ? m1.be    : 4'hF;
  assign s.wdata = sel ? m1.wdata : '0;

  assign m0.gnt    = grant && !sel;
  assign m1.gnt    = grant &&  sel;
  assign m0.rvalid = pop && !head;
  assign m1.rvalid = pop &&  head;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;

  assign outstanding_o = count_q;
  assign err_o         = err_q;

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      rr_q      <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      // Hold the selection while a presented request waits for its grant;
      // the lock also drops if the request disappears.
      lock_q    <= s_req && !s.gnt;
      lock_id_q <= sel;

      if (grant) begin
        rr_q     <= !sel;
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);

      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (s.rvalid && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // ID storage
  always_ff @(posedge clk_i) begin
    if (grant) fifo_q[wr_ptr_q] <= sel;
  end

endmodule
